// File: rtl/zad5_logic_cell_if.sv
// Port bundle for the programmable two-input logic cell: operands, table
// configuration and counter clear in, combinational/registered results out.
interface zad5_logic_cell_if #(
    parameter int CNT_W = 8
);
    logic             a;
    logic             b;
    logic             cfg_we;
    logic [3:0]       cfg_tt;
    logic             cnt_clr;
    logic             c;
    logic             c_q;
    logic             rise;
    logic             fall;
    logic [3:0]       tt_q;
    logic [CNT_W-1:0] tog_cnt;

    modport master (
        output a, b, cfg_we, cfg_tt, cnt_clr,
        input  c, c_q, rise, fall, tt_q, tog_cnt
    );

    modport slave (
        input  a, b, cfg_we, cfg_tt, cnt_clr,
        output c, c_q, rise, fall, tt_q, tog_cnt
    );
endinterface

// File: rtl/zad5_logic_cell.sv
// Two-input logic cell driven by a 4-bit truth table, with a registered copy
// of the result, rise/fall pulses on that copy and a saturating toggle counter.
module zad5_logic_cell #(
    parameter logic [3:0] TT_INIT = 4'b0110,
    parameter int         CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    zad5_logic_cell_if.slave       bus
);
    logic [3:0]       tt_q,   tt_d;
    logic             c_q,    c_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             c_w;

    // The table lookup always uses the pre-edge table, so a write only
    // affects c (and hence c_q) from the cycle after it lands.
    assign c_w = tt_q[{bus.a, bus.b}];

    always_comb begin
        tt_d   = tt_q;
        c_d    = c_w;
        rise_d = c_w & ~c_q;
        fall_d = ~c_w & c_q;
        cnt_d  = cnt_q;
        if (bus.cfg_we) begin
            tt_d = bus.cfg_tt;
        end
        // Clear takes priority over counting a coincident transition.
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if ((c_w != c_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q   <= TT_INIT;
            c_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            tt_q   <= tt_d;
            c_q    <= c_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.c       = c_w;
    assign bus.c_q     = c_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.tt_q    = tt_q;
    assign bus.tog_cnt = cnt_q;
endmodule

// File: tb/tb_zad5_logic_cell.sv
// Directed bench for zad5_logic_cell: unclocked lookup, clocked sweep, table
// write timing, counter saturation and clear, asynchronous reset.
module tb_zad5_logic_cell;
    logic clk;
    logic rst;
    logic clk_run;
    int   checks;
    int   errors;

    zad5_logic_cell_if #(.CNT_W(8)) bus ();

    zad5_logic_cell #(.TT_INIT(4'b0110), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = clk_run ? ~clk : 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s got=%0d t=%0t", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [3:0] xor_exp;
        bit [3:0] rise_exp;
        bit [3:0] fall_exp;
        bit [3:0] cq_exp;
        xor_exp  = 4'b0110;
        cq_exp   = 4'b0110;
        rise_exp = 4'b0010;
        fall_exp = 4'b1000;
        checks   = 0;
        errors   = 0;
        clk_run  = 1'b0;
        rst      = 1'b1;
        bus.a = 0; bus.b = 0; bus.cfg_we = 0; bus.cfg_tt = 4'h0; bus.cnt_clr = 0;
        #2;
        bus.b = 1'b1;
        #1;
        check("c_in_reset", bus.c, 1);
        bus.b = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("rst_tt", bus.tt_q, 4'b0110);
        check("rst_cq", bus.c_q, 0);
        check("rst_rise", bus.rise, 0);
        check("rst_fall", bus.fall, 0);
        check("rst_cnt", bus.tog_cnt, 0);

        // Unclocked lookup with the default XOR table.
        for (int i = 0; i < 4; i++) begin
            {bus.a, bus.b} = 2'(i);
            #2;
            check($sformatf("c_comb_%0d", i), bus.c, xor_exp[i]);
        end

        // Clocked sweep: c_q follows one cycle late.
        {bus.a, bus.b} = 2'b00;
        clk_run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {bus.a, bus.b} = 2'(i);
            tick();
            check($sformatf("sweep_cq_%0d", i), bus.c_q, cq_exp[i]);
            check($sformatf("sweep_rise_%0d", i), bus.rise, rise_exp[i]);
            check($sformatf("sweep_fall_%0d", i), bus.fall, fall_exp[i]);
        end
        check("sweep_cnt", bus.tog_cnt, 2);

        // Load AND while {a,b}=11: old table applies until the edge.
        {bus.a, bus.b} = 2'b11;
        bus.cfg_we = 1'b1;
        bus.cfg_tt = 4'b1000;
        #1;
        check("and_pre_c", bus.c, 0);
        tick();
        bus.cfg_we = 1'b0;
        check("and_tt", bus.tt_q, 4'b1000);
        check("and_post_c", bus.c, 1);
        check("and_post_cq", bus.c_q, 0);
        tick();
        check("and_cq", bus.c_q, 1);
        check("and_rise", bus.rise, 1);
        check("and_cnt", bus.tog_cnt, 3);

        // Back to XOR (no transition: c=1 under AND, c_q=1).
        bus.cfg_we = 1'b1;
        bus.cfg_tt = 4'b0110;
        tick();
        bus.cfg_we = 1'b0;
        check("xor_tt", bus.tt_q, 4'b0110);
        check("xor_cnt", bus.tog_cnt, 3);

        // Toggle a every cycle: one transition per cycle, saturating at 255.
        bus.b = 1'b0;
        for (int k = 0; k < 300; k++) begin
            bus.a = k[0];
            tick();
            check("excl", {31'd0, bus.rise & bus.fall}, 0);
            if (k == 99)  check("cnt_mid", bus.tog_cnt, 103);
            if (k == 251) check("cnt_252", bus.tog_cnt, 255);
        end
        check("cnt_sat", bus.tog_cnt, 255);
        for (int k = 0; k < 4; k++) begin
            bus.a = ~bus.a;
            tick();
        end
        check("cnt_hold", bus.tog_cnt, 255);

        // Clear coinciding with a transition: clear wins.
        bus.a = ~bus.a;
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        check("clr_cnt", bus.tog_cnt, 0);
        bus.a = ~bus.a;
        tick();
        check("clr_next", bus.tog_cnt, 1);

        // Set up tt=1110, c_q=1, then reset asynchronously mid-cycle.
        {bus.a, bus.b} = 2'b01;
        bus.cfg_we = 1'b1;
        bus.cfg_tt = 4'b1110;
        tick();
        bus.cfg_we = 1'b0;
        tick();
        check("pre_rst_tt", bus.tt_q, 4'b1110);
        check("pre_rst_cq", bus.c_q, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tt", bus.tt_q, 4'b0110);
        check("arst_cq", bus.c_q, 0);
        check("arst_cnt", bus.tog_cnt, 0);
        check("arst_c", bus.c, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_cq", bus.c_q, 1);
        check("post_rst_rise", bus.rise, 1);
        check("post_rst_cnt", bus.tog_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
